fp_mult_scheduler: RTL

Shares one combinational FP32 multiplier among NUM_REQ requesters. Requesters are served round-robin over a valid/ready handshake. The block registers the granted operands, waits MUL_LAT cycles for the multiplier, then returns product, flags and requester ID on a single response channel. It sits between the requesting pipeline stages and the FP32 multiplier datapath, and keeps operation and exception counters for status readout.

---
 rtl/fp_mult_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fp_mult_scheduler.sv
// Round-robin scheduler sharing one combinational FP32 multiplier
// among NUM_REQ requesters, with op/exception status counters.
module fp_mult_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_product,
  output logic [2:0]           rsp_flags,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_product,
  input  logic                 mul_exception,
  input  logic                 mul_overflow,
  input  logic                 mul_underflow,
  output logic                 busy,
  output logic [15:0]          op_count,
  output logic [15:0]          exc_count
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] lo_idx;
  logic [ID_W-1:0] hi_idx;
  logic            lo_f;
  logic            hi_f;
  logic [CW-1:0]   wait_cnt;
  logic            accept;
  logic            wait_done;
  logic            rsp_fire;

  // Prefer the lowest valid index at or above rr_ptr, else wrap to lowest.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    lo_f   = 1'b0;
    hi_f   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = ID_W'(i);
        lo_f   = 1'b1;
        if (ID_W'(i) >= rr_ptr) begin
          hi_idx = ID_W'(i);
          hi_f   = 1'b1;
        end
      end
    end
    grant = hi_f ? hi_idx : lo_idx;
  end

  assign accept    = (state_q == IDLE) && lo_f;
  assign wait_done = (state_q == WAIT) && (wait_cnt == '0);
  assign rsp_fire  = (state_q == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (lo_f) state_d = WAIT;
      WAIT:    if (wait_cnt == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      id_reg      <= '0;
      wait_cnt    <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_flags   <= '0;
      op_count    <= '0;
      exc_count   <= '0;
    end else begin
      if (accept) begin
        mul_a    <= req_a[32*grant +: 32];
        mul_b    <= req_b[32*grant +: 32];
        id_reg   <= grant;
        rr_ptr   <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
        wait_cnt <= CW'(MUL_LAT - 1);
      end
      if (state_q == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - CW'(1);
      if (wait_done) begin
        rsp_product <= mul_product;
        rsp_flags   <= {mul_exception, mul_overflow, mul_underflow};
        rsp_id      <= id_reg;
        rsp_valid   <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
        if ((|rsp_flags) && exc_count != 16'hFFFF)
          exc_count <= exc_count + 16'd1;
      end
    end
  end

endmodule
